swchrsp_pkt_unloader: RTL and testbench
=======================================

// Module: swchrsp_pkt_unloader
// PURPOSE
//  Downstream consumer of the switch-response packet FIFO (dma_fifo_exmem_swchrsp).
//  Pops one length-header word, then the packet's data words, and emits them as a
//  framed valid/ready stream (sop/eop/keep) toward the MAC TX path.
//  Bad headers are discarded and flagged. A one-deep output register decouples FIFO
//  head from downstream backpressure.
// PARAMETERS
//  DWIDTH   64    FIFO/stream word width, bits; power of 2, >=16
//  LWIDTH   16    length field width, header bits [LWIDTH-1:0] = packet bytes
//  MAX_LEN  1518  largest legal packet length in bytes
// PORTS
//  clks.clk    in   1            clock (AXI_clks.to_rtl port clks)
//  clks.rst    in   1            asynchronous reset, active-low
//  fifo_data   in   DWIDTH       FIFO head word; valid whenever !fifo_empty
//  fifo_empty  in   1            FIFO empty flag
//  fifo_pull   out  1            pop FIFO head this cycle (combinational)
//  m_valid     out  1            output word valid
//  m_ready     in   1            downstream accepts word when m_valid&&m_ready
//  m_data      out  DWIDTH       output word, byte 0 = bits [7:0]
//  m_keep      out  DWIDTH/8     byte enables, contiguous from byte 0
//  m_sop       out  1            first word of packet
//  m_eop       out  1            last word of packet
//  busy        out  1            state != IDLE or m_valid
//  err_len     out  1            1-cycle pulse: header dropped (L==0 or L>MAX_LEN)
//  pkt_cnt     out  32           packets fully emitted (eop accepted), wraps
// BEHAVIOUR
//  Reset (clks.rst low, async): state=IDLE; m_valid,m_sop,m_eop,err_len=0;
//   m_data=0, m_keep=0, pkt_cnt=0, internal word counter=0. fifo_pull=0 in reset.
//  BYTES=DWIDTH/8. Header word: L=fifo_data[LWIDTH-1:0]; upper bits ignored.
//  W=ceil(L/BYTES) data words; last keep=(L%BYTES==0)? all-ones : (1<<(L%BYTES))-1.
//  FSM:
//   IDLE: if !fifo_empty -> fifo_pull=1 (header pop), latch L, W.
//         L==0 or L>MAX_LEN -> err_len=1 next cycle, stay IDLE (no data words popped).
//         else -> DATA, words_left=W, first=1.
//   DATA: load = (!m_valid || m_ready) && !fifo_empty. On load: fifo_pull=1,
//         m_data<=fifo_data, m_valid<=1, m_sop<=first, first<=0,
//         m_eop<=(words_left==1), m_keep<=(words_left==1)? last keep : all-ones,
//         words_left--. Last word loaded -> IDLE.
//         m_valid&&m_ready && !load -> m_valid<=0 (keep/sop/eop don't-care).
//  Latency: FIFO head -> m_data one cycle. Full throughput 1 word/cycle in DATA.
//   Header pop costs one bubble cycle between packets; header pop in IDLE may overlap
//   a pending output word (output register untouched in IDLE, still drains on m_ready).
//  Output hold: while m_valid&&!m_ready, m_data/keep/sop/eop/valid are stable.
//  fifo_pull never asserted when fifo_empty=1 (FIFO asserts on pull-when-empty).
//  FIFO empty mid-packet: stall in DATA, no pull, m_valid drops once current word taken.
//  pkt_cnt increments on cycle m_valid&&m_ready&&m_eop; wraps 2^32-1 -> 0.
//  Single-word packet (L<=BYTES): m_sop=m_eop=1 same word.
//  Reset mid-packet: all state cleared, partial packet lost, no eop emitted; FIFO
//   shares clks.rst so its pointers also clear.
// TESTING
//  1. L=16 hdr + words A,B, m_ready=1 -> 2 outputs: A sop keep=FF; B eop keep=FF; pkt_cnt=1.
//  2. L=13 -> 2 words, 2nd m_keep=8'h1F, m_eop=1; L=8 -> one word sop=eop=1 keep=FF.
//  3. L=0, then L=1519 headers -> err_len pulses twice, only 2 pulls, no m_valid, pkt_cnt=0.
//  4. L=64 (8 words), m_ready toggles 1/0 each cycle -> data order kept, words held
//     stable while !m_ready, fifo_pull never when empty, 8 accepts, one eop.
//  5. Two back-to-back L=24 pkts prefilled -> 3+3 words, exactly 1 bubble between, pkt_cnt=2.
//  6. Assert clks.rst low after 2nd of 4 words -> all outputs 0 immediately; after
//     release with new L=8 packet -> clean sop/eop word, pkt_cnt=1.

Source files
------------

// File: rtl/swchrsp_pkt_unloader.sv
// swchrsp_pkt_unloader
// Drains the switch-response packet FIFO: pops a length header, then the packet's
// data words, and presents them as a framed valid/ready stream (sop/eop/keep).
// Headers with an illegal length are dropped and flagged with a one-cycle pulse.
// A single output register decouples the FIFO head from downstream backpressure.
module swchrsp_pkt_unloader #(
    parameter int DWIDTH  = 64,
    parameter int LWIDTH  = 16,
    parameter int MAX_LEN = 1518
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DWIDTH-1:0]   i_fifo_data,
    input  logic                i_fifo_empty,
    output logic                o_fifo_pull,
    output logic                o_m_valid,
    input  logic                i_m_ready,
    output logic [DWIDTH-1:0]   o_m_data,
    output logic [DWIDTH/8-1:0] o_m_keep,
    output logic                o_m_sop,
    output logic                o_m_eop,
    output logic                o_busy,
    output logic                o_err_len,
    output logic [31:0]         o_pkt_cnt
);

    localparam int BYTES = DWIDTH / 8;
    localparam int BSH   = $clog2(BYTES);

    typedef enum logic {S_IDLE, S_DATA} state_t;

    // Byte enables for the final word: the low 'rem' bytes, or all bytes when
    // the length is a whole number of words.
    function automatic logic [BYTES-1:0] f_last_keep(input logic [BSH-1:0] rem);
        logic [BYTES-1:0] k;
        k = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (BSH'(b) < rem) k[b] = 1'b1;
        end
        if (rem == '0) k = '1;
        return k;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LWIDTH-1:0]  r_words_left;
    logic [BYTES-1:0]   r_last_keep;
    logic               r_first;
    logic               r_m_valid;
    logic [DWIDTH-1:0]  r_m_data;
    logic [BYTES-1:0]   r_m_keep;
    logic               r_m_sop;
    logic               r_m_eop;
    logic               r_err_len;
    logic [31:0]        r_pkt_cnt;

    logic               w_hdr_pop;
    logic               w_load;
    logic               w_last;
    logic [LWIDTH-1:0]  w_hdr_len;
    logic [BSH-1:0]     w_hdr_rem;
    logic [LWIDTH-1:0]  w_hdr_words;
    logic               w_hdr_bad;

    // Header decode: word count rounds up, partial last word sets last keep.
    assign w_hdr_len   = i_fifo_data[LWIDTH-1:0];
    assign w_hdr_rem   = w_hdr_len[BSH-1:0];
    assign w_hdr_words = LWIDTH'(w_hdr_len >> BSH) + LWIDTH'(|w_hdr_rem);
    assign w_hdr_bad   = (w_hdr_len == '0) || (w_hdr_len > LWIDTH'(MAX_LEN));
    assign w_last      = (r_words_left == LWIDTH'(1));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state, header pop and data-word load decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_hdr_pop   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!i_fifo_empty) begin
                    w_hdr_pop = 1'b1;
                    if (!w_hdr_bad) w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if ((!r_m_valid || i_m_ready) && !i_fifo_empty) begin
                    w_load = 1'b1;
                    if (w_last) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Packet bookkeeping: latched word count, last keep, first-word flag, error pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_words_left <= '0;
            r_last_keep  <= '0;
            r_first      <= 1'b0;
            r_err_len    <= 1'b0;
        end else begin
            r_err_len <= w_hdr_pop && w_hdr_bad;
            if (w_hdr_pop && !w_hdr_bad) begin
                r_words_left <= w_hdr_words;
                r_last_keep  <= f_last_keep(w_hdr_rem);
                r_first      <= 1'b1;
            end else if (w_load) begin
                r_words_left <= r_words_left - LWIDTH'(1);
                r_first      <= 1'b0;
            end
        end
    end

    // Output register: loads from the FIFO head, holds under backpressure, drains when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_sop   <= 1'b0;
            r_m_eop   <= 1'b0;
        end else if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_data  <= i_fifo_data;
            r_m_keep  <= w_last ? r_last_keep : '1;
            r_m_sop   <= r_first;
            r_m_eop   <= w_last;
        end else if (r_m_valid && i_m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    // Count packets whose eop word was accepted downstream.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                               r_pkt_cnt <= '0;
        else if (r_m_valid && i_m_ready && r_m_eop) r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end

    // The FIFO shares this reset, so never pop while it is held.
    assign o_fifo_pull = i_rst_n && (w_hdr_pop || w_load);
    assign o_m_valid   = r_m_valid;
    assign o_m_data    = r_m_data;
    assign o_m_keep    = r_m_keep;
    assign o_m_sop     = r_m_sop;
    assign o_m_eop     = r_m_eop;
    assign o_err_len   = r_err_len;
    assign o_pkt_cnt   = r_pkt_cnt;
    assign o_busy      = (r_state != S_IDLE) || r_m_valid;

endmodule

// File: tb/tb_swchrsp_pkt_unloader.sv
// Bench for swchrsp_pkt_unloader: a queue stands in for the packet FIFO and a
// scoreboard queue holds the words the stream should produce.
module tb_swchrsp_pkt_unloader;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        s;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] fifo_data;
    logic        fifo_empty;
    logic        m_ready;
    logic        o_fifo_pull, o_m_valid, o_m_sop, o_m_eop, o_busy, o_err_len;
    logic [63:0] o_m_data;
    logic [7:0]  o_m_keep;
    logic [31:0] o_pkt_cnt;

    logic [63:0] fifo_q[$];
    exp_t        exp_q[$];

    int n_vec = 0, n_miss = 0;
    int n_pull = 0, n_err = 0, n_vld = 0, n_acc = 0, n_eop = 0;
    int cyc = 0, last_acc = -1000, sop_gap = 0;
    logic         prev_stall = 1'b0;
    logic [127:0] snap = '0;
    exp_t         e_mon;

    swchrsp_pkt_unloader #(.DWIDTH(64), .LWIDTH(16), .MAX_LEN(1518)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fifo_data(fifo_data), .i_fifo_empty(fifo_empty), .o_fifo_pull(o_fifo_pull),
        .o_m_valid(o_m_valid), .i_m_ready(m_ready), .o_m_data(o_m_data), .o_m_keep(o_m_keep),
        .o_m_sop(o_m_sop), .o_m_eop(o_m_eop), .o_busy(o_busy), .o_err_len(o_err_len),
        .o_pkt_cnt(o_pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 64'd0 : fifo_q[0];
    endtask

    // Header plus data words into the FIFO; legal packets also go to the scoreboard.
    task automatic push_pkt(input int len);
        int w, rem;
        logic [63:0] d;
        exp_t e;
        fifo_q.push_back({32'($urandom), 16'($urandom), 16'(len)});
        if (len != 0 && len <= 1518) begin
            w   = (len + 7) / 8;
            rem = len % 8;
            for (int i = 0; i < w; i++) begin
                d = {32'($urandom), 32'($urandom)};
                fifo_q.push_back(d);
                e.d = d;
                e.s = (i == 0);
                e.e = (i == w - 1);
                e.k = (i == w - 1 && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
                exp_q.push_back(e);
            end
        end
        upd_fifo();
    endtask

    task automatic wait_drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !o_busy) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 128'(done), 128'(1));
    endtask

    // FIFO model: pop the head after every edge on which the DUT pulled.
    always @(posedge clk) begin
        if (o_fifo_pull) begin
            #1;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            upd_fifo();
        end
    end

    // Monitor: pull legality, output hold under backpressure, scoreboard compare.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("pull_when_empty", 128'(o_fifo_pull & fifo_empty), 128'(0));
            if (o_fifo_pull) n_pull++;
            if (o_err_len)   n_err++;
            if (o_m_valid)   n_vld++;
            if (prev_stall)
                check("hold", 128'({o_m_valid, o_m_sop, o_m_eop, o_m_keep, o_m_data}), snap);
            if (o_m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 128'(o_m_valid), 128'(0));
                end else begin
                    e_mon = exp_q.pop_front();
                    check("word", 128'({o_m_data, o_m_keep, o_m_sop, o_m_eop}),
                          128'({e_mon.d, e_mon.k, e_mon.s, e_mon.e}));
                end
                if (o_m_sop) sop_gap = cyc - last_acc;
                last_acc = cyc;
                n_acc++;
                if (o_m_eop) n_eop++;
            end
            prev_stall = o_m_valid && !m_ready;
            snap = 128'({o_m_valid, o_m_sop, o_m_eop, o_m_keep, o_m_data});
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int b_acc, b_pull, b_err, b_vld, b_eop;
        bit hit;
        rst_n   = 1'b0;
        m_ready = 1'b1;
        upd_fifo();
        repeat (3) @(negedge clk);
        check("reset_outs", 128'({o_fifo_pull, o_m_valid, o_m_sop, o_m_eop, o_err_len,
                                 o_busy, o_m_keep, o_m_data, o_pkt_cnt}), 128'(0));
        @(posedge clk); #2 rst_n = 1'b1;

        // 1: two full words
        @(posedge clk); #2;
        b_acc = n_acc;
        push_pkt(16);
        wait_drain("t1_drain");
        check("t1_pkt_cnt", 128'(o_pkt_cnt), 128'(1));
        check("t1_words", 128'(n_acc - b_acc), 128'(2));

        // 2: partial last word, then a single-word packet
        @(posedge clk); #2;
        push_pkt(13);
        push_pkt(8);
        wait_drain("t2_drain");
        check("t2_pkt_cnt", 128'(o_pkt_cnt), 128'(3));

        // 3: illegal lengths are dropped
        @(posedge clk); #2;
        b_pull = n_pull; b_err = n_err; b_vld = n_vld;
        push_pkt(0);
        push_pkt(1519);
        repeat (8) @(negedge clk);
        #1;
        check("t3_err_pulses", 128'(n_err - b_err), 128'(2));
        check("t3_pulls", 128'(n_pull - b_pull), 128'(2));
        check("t3_no_valid", 128'(n_vld - b_vld), 128'(0));
        check("t3_pkt_cnt", 128'(o_pkt_cnt), 128'(3));
        check("t3_idle", 128'(o_busy), 128'(0));

        // 4: eight words with ready toggling every cycle
        @(posedge clk); #2;
        b_acc = n_acc; b_eop = n_eop;
        push_pkt(64);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            m_ready = ~m_ready;
            if (exp_q.size() == 0 && !o_busy) break;
        end
        m_ready = 1'b1;
        wait_drain("t4_drain");
        check("t4_accepts", 128'(n_acc - b_acc), 128'(8));
        check("t4_eops", 128'(n_eop - b_eop), 128'(1));
        check("t4_pkt_cnt", 128'(o_pkt_cnt), 128'(4));

        // 5: back-to-back packets prefilled, one bubble for the second header
        @(posedge clk); #2;
        b_acc = n_acc;
        push_pkt(24);
        push_pkt(24);
        wait_drain("t5_drain");
        check("t5_accepts", 128'(n_acc - b_acc), 128'(6));
        check("t5_sop_gap", 128'(sop_gap), 128'(2));
        check("t5_pkt_cnt", 128'(o_pkt_cnt), 128'(6));

        // 6: reset after the second of four words
        @(posedge clk); #2;
        b_acc = n_acc;
        push_pkt(32);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (n_acc - b_acc >= 2) begin
                hit = 1'b1;
                break;
            end
        end
        check("t6_two_words", 128'(hit), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t6_reset_outs", 128'({o_fifo_pull, o_m_valid, o_m_sop, o_m_eop, o_err_len,
                                    o_busy, o_m_keep, o_m_data, o_pkt_cnt}), 128'(0));
        fifo_q.delete();
        exp_q.delete();
        upd_fifo();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        b_acc = n_acc;
        @(posedge clk); #2;
        push_pkt(8);
        wait_drain("t6_drain");
        check("t6_words", 128'(n_acc - b_acc), 128'(1));
        check("t6_pkt_cnt", 128'(o_pkt_cnt), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
